// File: rtl/sram512_arb_pkg.sv
// Shared widths, parking default and requester tag type for the sram512_arb slice.
package sram512_arb_pkg;

  localparam int SRAM_AW = 9;
  localparam int SRAM_DW = 64;
  localparam logic [SRAM_AW-1:0] PARK_ADDR_DEF = 9'd511;
  localparam int MAX_REQ = 4;

  typedef logic [MAX_REQ-1:0] req_tag_t;

  function automatic logic tag_any(input req_tag_t tag);
    return |tag;
  endfunction

endpackage

// File: rtl/sram512_arb_if.sv
// Requester-side write/read handshake and response bus of sram512_arb.
interface sram512_arb_if #(parameter int NUM_REQ = 2) ();
  import sram512_arb_pkg::*;

  logic [NUM_REQ-1:0]              wr_valid;
  logic [NUM_REQ-1:0][SRAM_AW-1:0] wr_addr;
  logic [NUM_REQ-1:0][SRAM_DW-1:0] wr_data;
  logic [NUM_REQ-1:0]              wr_ready;
  logic [NUM_REQ-1:0]              rd_valid;
  logic [NUM_REQ-1:0][SRAM_AW-1:0] rd_addr;
  logic [NUM_REQ-1:0]              rd_ready;
  logic [NUM_REQ-1:0]              rd_rsp_valid;
  logic [SRAM_DW-1:0]              rd_rsp_data;

  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    input  wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr,
    output wr_ready, rd_ready, rd_rsp_valid, rd_rsp_data
  );

endinterface

// File: rtl/sram512_arb_rr_arb.sv
// Round-robin arbiter: search starts at the pointer, pointer moves past each winner.
module rr_arb #(
  parameter int N = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] win_s;
  logic          found_s;
  logic [N-1:0]  gnt_s;
  logic [PW:0]   cand_s [N];

  // first requester at or after the pointer, wrapping modulo N
  always_comb begin
    gnt_s   = '0;
    win_s   = '0;
    found_s = 1'b0;
    for (int k = 0; k < N; k++) begin
      cand_s[k] = {1'b0, ptr_q} + (PW+1)'(k);
      if (cand_s[k] >= (PW+1)'(N)) begin
        cand_s[k] = cand_s[k] - (PW+1)'(N);
      end else begin
        cand_s[k] = cand_s[k];
      end
      if (!found_s && req[cand_s[k][PW-1:0]]) begin
        found_s                   = 1'b1;
        win_s                     = cand_s[k][PW-1:0];
        gnt_s[cand_s[k][PW-1:0]]  = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  always_comb begin
    if (rst) begin
      gnt   = '0;
      ptr_d = ptr_q;
    end else if (found_s) begin
      gnt   = gnt_s;
      ptr_d = (win_s == PW'(N-1)) ? '0 : win_s + PW'(1);
    end else begin
      gnt   = gnt_s;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/sram512_arb.sv
// Shares one write and one read port of sram_512x64 among NUM_REQ requesters.
// Optional same-cycle write-to-read forwarding is enabled by defining SRAM_ARB_FWD_EN.
module sram512_arb
  import sram512_arb_pkg::*;
#(
  parameter int                 NUM_REQ   = 2,
  parameter logic [SRAM_AW-1:0] PARK_ADDR = PARK_ADDR_DEF
) (
  input  logic               clk,
  input  logic               rst,
  sram512_arb_if.slave       bus,
  output logic [SRAM_AW-1:0] sram_waddr,
  output logic [SRAM_DW-1:0] sram_wdata,
  output logic [SRAM_AW-1:0] sram_raddr,
  input  logic [SRAM_DW-1:0] sram_rdata
);

  logic [NUM_REQ-1:0] wr_gnt_s;
  logic [NUM_REQ-1:0] rd_gnt_s;
  logic               rd_park_s;
  logic [SRAM_DW-1:0] rdata_eff_s;

  req_tag_t           tag1_q, tag1_d;
  logic               park1_q, park1_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [SRAM_DW-1:0] rsp_data_q, rsp_data_d;

  rr_arb #(.N(NUM_REQ)) u_wr_arb (.clk(clk), .rst(rst), .req(bus.wr_valid), .gnt(wr_gnt_s));
  rr_arb #(.N(NUM_REQ)) u_rd_arb (.clk(clk), .rst(rst), .req(bus.rd_valid), .gnt(rd_gnt_s));

  assign bus.wr_ready     = wr_gnt_s;
  assign bus.rd_ready     = rd_gnt_s;
  assign bus.rd_rsp_valid = rsp_valid_q;
  assign bus.rd_rsp_data  = rsp_data_q;

  // idle write cycles land on the scratch address because the SRAM always writes
  always_comb begin
    sram_waddr = PARK_ADDR;
    sram_wdata = '0;
    sram_raddr = PARK_ADDR;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (wr_gnt_s[i]) begin
        sram_waddr = bus.wr_addr[i];
        sram_wdata = bus.wr_data[i];
      end else begin
        sram_waddr = sram_waddr;
      end
      if (rd_gnt_s[i]) begin
        sram_raddr = bus.rd_addr[i];
      end else begin
        sram_raddr = sram_raddr;
      end
    end
    rd_park_s = (|rd_gnt_s) && (sram_raddr == PARK_ADDR);
  end

`ifdef SRAM_ARB_FWD_EN
  logic               fwd_hit_q, fwd_hit_d;
  logic [SRAM_DW-1:0] fwd_data_q, fwd_data_d;

  always_comb begin
    fwd_hit_d  = (|wr_gnt_s) && (|rd_gnt_s) && (sram_waddr == sram_raddr) && !rd_park_s;
    fwd_data_d = sram_wdata;
    if (fwd_hit_q) begin
      rdata_eff_s = fwd_data_q;
    end else begin
      rdata_eff_s = sram_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fwd_hit_q  <= 1'b0;
      fwd_data_q <= '0;
    end else begin
      fwd_hit_q  <= fwd_hit_d;
      fwd_data_q <= fwd_data_d;
    end
  end
`else
  assign rdata_eff_s = sram_rdata;
`endif

  // tag stage 1 tracks the SRAM read cycle, stage 2 is the response pulse
  always_comb begin
    tag1_d      = req_tag_t'(rd_gnt_s);
    park1_d     = rd_park_s;
    rsp_valid_d = tag1_q[NUM_REQ-1:0];
    if (tag_any(tag1_q)) begin
      rsp_data_d = park1_q ? '0 : rdata_eff_s;
    end else begin
      rsp_data_d = rsp_data_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tag1_q      <= '0;
      park1_q     <= 1'b0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      tag1_q      <= tag1_d;
      park1_q     <= park1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

endmodule

// File: doc/sram512_arb.md
# sram512_arb

Two-port arbiter in front of `sram_512x64`, sharing its single write port and single read port between `NUM_REQ` requesters. Write and read requests use valid/ready handshakes with independent round-robin arbitration. Read data returns on a per-requester response pulse. The SRAM write enable is permanently active, so the block parks idle write cycles on a reserved scratch address.

## Interface
Parameters:
- `NUM_REQ`, 2: number of requesters, 2..4.
- `PARK_ADDR`, 9'd511: scratch address written on idle cycles. Reserved; not usable for storage.

Ports:
- `clk`  in  1  single clock for block and SRAM.
- `rst`  in  1  reset, asynchronous, active-high.
- `wr_valid`  in  NUM_REQ  per-requester write request.
- `wr_addr`  in  NUM_REQ×9  write address per requester.
- `wr_data`  in  NUM_REQ×64  write data per requester.
- `wr_ready`  out  NUM_REQ  one-hot write grant; the write is performed in this cycle.
- `rd_valid`  in  NUM_REQ  per-requester read request.
- `rd_addr`  in  NUM_REQ×9  read address per requester.
- `rd_ready`  out  NUM_REQ  one-hot read grant.
- `rd_rsp_valid`  out  NUM_REQ  one-cycle response pulse.
- `rd_rsp_data`  out  64  response data, shared by all requesters.
- `sram_waddr`  out  9  to `sram_512x64.waddr`.
- `sram_wdata`  out  64  to `sram_512x64.wdata`.
- `sram_raddr`  out  9  to `sram_512x64.raddr`.
- `sram_rdata`  in  64  from `sram_512x64.rdata`; valid one cycle after `sram_raddr`.

## Operation
- **Handshake.** A transfer occurs when `valid & ready`. A requester holds valid, address and data stable until ready. `ready` is combinational from `valid` and the RR pointer; it is never asserted without `valid`.
- **Write path.**
  - The RR arbiter picks at most one `wr_valid` per cycle.
  - With a grant: `sram_waddr`/`sram_wdata` are driven from the winner's `wr_addr`/`wr_data`.
  - With no grant: `sram_waddr`=`PARK_ADDR` and `sram_wdata`=0.
- **Read path.**
  - The RR arbiter picks at most one `rd_valid` per cycle and drives `sram_raddr` from the winner.
  - With no grant: `sram_raddr`=`PARK_ADDR`.
  - The grant is registered through a 2-stage one-hot tag pipeline.
- **Round robin.**
  - Each arbiter has its own pointer, reset to 0.
  - Search order starts at the pointer.
  - After a grant to requester i, the pointer moves to (i+1) mod NUM_REQ.
  - With no grant, the pointer holds.
- **Parking address.**
  - A write to `PARK_ADDR` is accepted normally and has no guaranteed effect.
  - A read of `PARK_ADDR` is accepted and returns `rd_rsp_data`=64'h0.
- **Read/write ordering.**
  - A write granted in cycle N is visible to a read granted in cycle N+1 or later.
  - A same-cycle read and write to one address: the response is the old data unless `SRAM_ARB_FWD_EN` is defined.
- **Reset mid-operation.** In-flight read responses are discarded, no `rd_rsp_valid` is issued for them, and both pointers return to 0.

## Timing
- Write: zero-latency grant; the SRAM write happens at the `clk` edge that ends the grant cycle.
- Read:
  - grant in cycle N;
  - `sram_rdata` valid in N+1, registered into `rd_rsp_data`;
  - `rd_rsp_valid[i]` high for exactly one cycle in N+2.
- Throughput: one read and one write per cycle, concurrently.
- Responses have no backpressure. Responses return in grant order.
- Reset values:
  - `wr_ready`=0, `rd_ready`=0 while `rst` is high;
  - `rd_rsp_valid`=0, `rd_rsp_data`=0;
  - `sram_waddr`=`sram_raddr`=`PARK_ADDR`, `sram_wdata`=0.

## Configuration
- `SRAM_ARB_FWD_EN` defined:
  - The write address/data granted in cycle N are registered.
  - If the read granted in N has the same address, the registered `wr_data` replaces `sram_rdata` in N+1.
  - The response therefore carries the new data.
  - Excluded when the address is `PARK_ADDR`.
- Undefined: no forwarding logic; a same-cycle same-address read returns the pre-write contents.

## Structure
- Package `sram512_arb_pkg`:
  - `SRAM_AW`=9, `SRAM_DW`=64, `PARK_ADDR_DEF`=9'd511;
  - `req_tag_t` (one-hot requester tag).
- Sub-module `rr_arb`:
  - parameter `N`;
  - inputs: `clk`, `rst`, `req[N]`;
  - output: one-hot `gnt[N]`;
  - internal pointer register.
  - Instantiated twice, for write and read.
- The top level holds the muxes, the read tag/valid pipeline, the response register and the optional forwarding registers.

## Test plan
- **Single write then read.** Req0 writes 0xDEADBEEF_00000001 to addr 5; req1 reads addr 5 two cycles later. Expect `rd_rsp_valid[1]` 2 cycles after grant, with that data.
- **Read contention.** Both requesters hold `rd_valid` continuously for 6 cycles after reset. Expect grants 0,1,0,1,0,1 and responses in the same order at +2.
- **Idle write parking.** No `wr_valid` for 10 cycles. Expect `sram_waddr`=511 and `sram_wdata`=0 throughout; earlier data at addrs 0–510 is unchanged.
- **Same-cycle collision at addr 20.** Old value 0x1, new write 0x2. Expect response 0x2 with `SRAM_ARB_FWD_EN` defined, 0x1 without.
- **Reset mid-read.** Assert `rst` 1 cycle after a read grant. Expect no `rd_rsp_valid`, all outputs at reset values, and a first post-reset grant to req0.
- **Read of `PARK_ADDR`.** Read addr 511. Expect the response 2 cycles later with data 64'h0.
